decoder_rr_arbiter: RTL and testbench

DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

---
 rtl/decoder_arb_pkg.sv | 13 +
 rtl/decoder_rr_arbiter_decoder.sv | 15 +
 rtl/decoder_rr_arbiter.sv | 129 ++++++++++++
 tb/tb_decoder_rr_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_arb_pkg.sv
// Shared definitions for decoder_rr_arbiter: FSM state encoding and the
// width of the optional grant-hold counter.
package decoder_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Hold counter width; TIMEOUT is limited to 2..255 so it always fits.
  localparam int CNT_W = 8;

endpackage

// File: rtl/decoder_rr_arbiter_decoder.sv
// Parameterised binary-to-one-hot decoder with an enable gate.
// Output is all-zero when en is low, otherwise exactly bit [sel] is set.
module decoder #(
  parameter int N = 2
) (
  input  logic [N-1:0]    sel,
  input  logic            en,
  output logic [2**N-1:0] out
);

  for (genvar i = 0; i < 2**N; i++) begin : g_bit
    assign out[i] = en && (sel == N'(i));
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter over 2**N requesters with an IDLE/BUSY grant FSM.
// A grant is held until the owner releases it (done or dropping its request);
// one idle cycle separates consecutive grants.
// Optional feature: define ARB_TIMEOUT_EN to revoke a grant held for TIMEOUT
// cycles and pulse timeout. Without it the grant is held indefinitely.
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int N       = 2,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2**N-1:0] req,
  input  logic            done,
  output logic [2**N-1:0] gnt,
  output logic [N-1:0]    gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam int R = 2**N;

  arb_state_e     state;
  logic [N-1:0]   ptr;
  logic [2*R-1:0] req_dbl;
  logic [R-1:0]   req_rot;
  logic [N-1:0]   first_off;
  logic [N-1:0]   pick;
  logic           release_now;

  // Rotate so bit 0 is the requester at ptr, then find the lowest set bit;
  // adding ptr back maps the offset to an absolute index modulo R.
  assign req_dbl = {req, req} >> ptr;
  assign req_rot = req_dbl[R-1:0];

  // Find-first from the bottom of the rotated vector.
  always_comb begin
    first_off = '0;
    for (int i = R - 1; i >= 0; i--) begin
      if (req_rot[i]) first_off = N'(i);
    end
  end

  assign pick        = ptr + first_off;
  assign release_now = done || !req[gnt_id];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  // Grant FSM with hold counter; a release on the timeout edge wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= BUSY;
            gnt_id    <= pick;
            ptr       <= pick + 1'b1;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end
        end
        BUSY: begin
          if (release_now) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
          end else if (hold_cnt == CNT_W'(TIMEOUT - 1)) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            hold_cnt  <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign timeout = timeout_q;
`else
  // Grant FSM: owner keeps the grant until it releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state     <= BUSY;
            gnt_id    <= pick;
            ptr       <= pick + 1'b1;
            gnt_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (release_now) begin
            state     <= IDLE;
            gnt_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  decoder #(.N(N)) decoder (
    .sel (gnt_id),
    .en  (gnt_valid),
    .out (gnt)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Self-checking bench for decoder_rr_arbiter (N=2, TIMEOUT=4).
// Directed scenarios plus randomized traffic against a cycle-level
// reference model of the arbitration rules.
module tb_decoder_rr_arbiter;

  localparam int N       = 2;
  localparam int TIMEOUT = 4;
  localparam int R       = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [R-1:0] req = '0;
  logic         done = 1'b0;
  logic [R-1:0] gnt;
  logic [N-1:0] gnt_id;
  logic         gnt_valid;
  logic         timeout;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // reference model state
  bit m_busy, m_to;
  int m_id, m_ptr, m_cnt;

  decoder_rr_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_to = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // One clock edge of the arbitration rules.
  task automatic model_step(input logic [R-1:0] r, input logic d);
    if (m_busy) begin
      if (d || !r[m_id]) begin
        m_busy = 0; m_to = 0;
      end else if (TO_EN && m_cnt == TIMEOUT - 1) begin
        m_busy = 0; m_to = 1;
      end else begin
        m_cnt++; m_to = 0;
      end
    end else begin
      m_to = 0;
      for (int i = 0; i < R; i++) begin
        if (!m_busy && r[(m_ptr + i) % R]) begin
          m_id   = (m_ptr + i) % R;
          m_ptr  = (m_id + 1) % R;
          m_busy = 1;
          m_cnt  = 0;
        end
      end
    end
  endtask

  function automatic logic [7:0] exp_vec();
    return {m_busy ? 4'(1 << m_id) : 4'b0000, 2'(m_id), logic'(m_busy), logic'(m_to)};
  endfunction

  // Advance one edge; inputs only change on negedges.
  task automatic tick();
    @(posedge clk);
    model_step(req, done);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; done = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== 8'h00)
      $display("FAIL reset: got %b exp %b", {gnt, gnt_id, gnt_valid, timeout}, 8'h00);
    else pass_cnt++;
    do_reset();
    chk_cnt++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== 8'h00)
      $display("FAIL reset_release: got %b exp %b", {gnt, gnt_id, gnt_valid, timeout}, 8'h00);
    else pass_cnt++;
  endtask

  task automatic test_single_grant();
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    chk_cnt++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2 || gnt_valid !== 1'b1)
      $display("FAIL single_grant: got gnt=%b id=%0d v=%b exp gnt=0100 id=2 v=1", gnt, gnt_id, gnt_valid);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if ({gnt, gnt_id, gnt_valid, timeout} !== exp_vec())
      $display("FAIL single_release: got %b exp %b", {gnt, gnt_id, gnt_valid, timeout}, exp_vec());
    else pass_cnt++;
    // ptr now 3: full request must go to index 3
    req = 4'b1111;
    tick();
    chk_cnt++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3)
      $display("FAIL ptr_after_2: got gnt=%b id=%0d exp gnt=1000 id=3", gnt, gnt_id);
    else pass_cnt++;
  endtask

  task automatic test_rotation();
    logic [R-1:0] seq [9];
    seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    req = 4'b1111; done = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      chk_cnt++;
      if (gnt !== seq[k] || {gnt, gnt_id, gnt_valid, timeout} !== exp_vec())
        $display("FAIL rotation step %0d: got gnt=%b exp %b", k, gnt, seq[k]);
      else pass_cnt++;
    end
    done = 1'b0; req = '0;
  endtask

  task automatic test_double_release();
    do_reset();
    req = 4'b0010;
    tick();
    chk_cnt++;
    if (gnt !== 4'b0010 || gnt_id !== 2'd1)
      $display("FAIL dbl_grant: got gnt=%b id=%0d exp gnt=0010 id=1", gnt, gnt_id);
    else pass_cnt++;
    req = 4'b0000; done = 1'b1;
    tick();
    done = 1'b0;
    chk_cnt++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0)
      $display("FAIL dbl_release: got gnt=%b v=%b to=%b exp 0000 0 0", gnt, gnt_valid, timeout);
    else pass_cnt++;
    // ptr must be 2, not 3
    req = 4'b1111;
    tick();
    chk_cnt++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2)
      $display("FAIL dbl_ptr: got gnt=%b id=%0d exp gnt=0100 id=2", gnt, gnt_id);
    else pass_cnt++;
    req = '0;
  endtask

  task automatic test_done_idle();
    do_reset();
    done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_cnt++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== 8'h00)
        $display("FAIL done_idle %0d: got %b exp %b", k, {gnt, gnt_id, gnt_valid, timeout}, 8'h00);
      else pass_cnt++;
    end
    done = 1'b0; req = 4'b1111;
    tick();
    chk_cnt++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0)
      $display("FAIL done_idle_ptr: got gnt=%b id=%0d exp gnt=0001 id=0", gnt, gnt_id);
    else pass_cnt++;
    req = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0100;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || gnt_id !== 2'd0 || timeout !== 1'b0)
      $display("FAIL async_reset: got gnt=%b v=%b id=%0d exp 0000 0 0", gnt, gnt_valid, gnt_id);
    else pass_cnt++;
    model_reset();
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1111;
    tick();
    chk_cnt++;
    if (gnt !== 4'b0001)
      $display("FAIL async_reset_ptr: got gnt=%b exp 0001", gnt);
    else pass_cnt++;
    req = '0;
  endtask

  task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
    do_reset();
    req = 4'b1000;
    tick();
    req = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_cnt++;
      if (gnt !== 4'b1000 || timeout !== 1'b0)
        $display("FAIL to_hold %0d: got gnt=%b to=%b exp 1000 0", k, gnt, timeout);
      else pass_cnt++;
    end
    tick();
    chk_cnt++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b1)
      $display("FAIL to_revoke: got gnt=%b v=%b to=%b exp 0000 0 1", gnt, gnt_valid, timeout);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (gnt !== 4'b0001 || timeout !== 1'b0)
      $display("FAIL to_next: got gnt=%b to=%b exp 0001 0", gnt, timeout);
    else pass_cnt++;
    // release on the timeout edge wins
    do_reset();
    req = 4'b1000;
    tick();
    tick(); tick(); tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk_cnt++;
    if (gnt_valid !== 1'b0 || timeout !== 1'b0)
      $display("FAIL to_release_same_edge: got v=%b to=%b exp 0 0", gnt_valid, timeout);
    else pass_cnt++;
`else
    do_reset();
    req = 4'b1000;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk_cnt++;
      if (gnt !== 4'b1000 || timeout !== 1'b0)
        $display("FAIL hold_forever %0d: got gnt=%b to=%b exp 1000 0", k, gnt, timeout);
      else pass_cnt++;
    end
`endif
    req = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 4) req = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 4) == 0);
      tick();
      chk_cnt++;
      if ({gnt, gnt_id, gnt_valid, timeout} !== exp_vec())
        $display("FAIL random cyc %0d: got %b exp %b", k, {gnt, gnt_id, gnt_valid, timeout}, exp_vec());
      else pass_cnt++;
    end
    req = '0; done = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_grant();
    test_rotation();
    test_double_release();
    test_done_idle();
    test_async_reset();
    test_timeout();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
